// File: rtl/sdram_regfile_pkg.sv
// Shared constants for the SDRAM mode/timing register file: LMR opcode,
// AddrIn field map, default reset values and zero-clamp helpers.
package sdram_regfile_pkg;

  // {CS, RAS, CAS, WeIn} pattern of the LOAD MODE REGISTER command
  localparam logic [3:0] LMR_OPCODE = 4'b0000;

  localparam int BC_LSB   = 0;
  localparam int BC_W     = 3;
  localparam int AM_LSB   = 3;
  localparam int AM_W     = 1;
  localparam int LAT_LSB  = 4;
  localparam int LAT_W    = 4;
  localparam int PRE_LSB  = 8;
  localparam int PRE_W    = 8;
  localparam int WAIT_LSB = 16;
  localparam int WAIT_W   = 8;
  localparam int CAS_LSB  = 24;
  localparam int CAS_W    = 8;

  localparam logic [7:0] DEF_TBURST = 8'd1;
  localparam logic [3:0] DEF_TLAT   = 4'd2;
  localparam logic [7:0] DEF_TPRE   = 8'd2;
  localparam logic [7:0] DEF_TWAIT  = 8'd2;
  localparam logic [7:0] DEF_TCAS   = 8'd2;

  // A zero timing field would stall a controller counter forever
  function automatic logic [7:0] nz8(input logic [7:0] v);
    return (v == 8'd0) ? 8'd1 : v;
  endfunction

  function automatic logic [3:0] nz4(input logic [3:0] v);
    return (v == 4'd0) ? 4'd1 : v;
  endfunction

endpackage

// File: rtl/sdram_burst_decode.sv
// Maps the 3-bit burst code to a beat count (1,2,4,...,128).
module sdram_burst_decode (
  input  logic [2:0] bc,
  output logic [7:0] beats
);

  assign beats = 8'd1 << bc;

endmodule

// File: rtl/sdram_mode_regfile.sv
// SDRAM mode/timing register file loaded by the LOAD MODE REGISTER command.
// Define SDRAM_REGFILE_CLAMP_EN to store zero timing fields as 1.
module sdram_mode_regfile
  import sdram_regfile_pkg::*;
#(
  parameter logic [7:0] RST_TBURST = DEF_TBURST,
  parameter logic [3:0] RST_TLAT   = DEF_TLAT,
  parameter logic [7:0] RST_TPRE   = DEF_TPRE,
  parameter logic [7:0] RST_TWAIT  = DEF_TWAIT,
  parameter logic [7:0] RST_TCAS   = DEF_TCAS
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        CS,
  input  logic        RAS,
  input  logic        CAS,
  input  logic        WeIn,
  input  logic [31:0] AddrIn,
  output logic [7:0]  tburst,
  output logic        addr_mode,
  output logic [3:0]  tlat,
  output logic [7:0]  tpre,
  output logic [7:0]  twait,
  output logic [7:0]  tcas
);

  logic       lmr;
  logic [7:0] beats;
  logic [3:0] lat_d;
  logic [7:0] pre_d;
  logic [7:0] wait_d;
  logic [7:0] cas_d;

  assign lmr = ({CS, RAS, CAS, WeIn} == LMR_OPCODE);

  sdram_burst_decode u_burst_decode (
    .bc    (AddrIn[BC_LSB +: BC_W]),
    .beats (beats)
  );

`ifdef SDRAM_REGFILE_CLAMP_EN
  assign lat_d  = nz4(AddrIn[LAT_LSB  +: LAT_W]);
  assign pre_d  = nz8(AddrIn[PRE_LSB  +: PRE_W]);
  assign wait_d = nz8(AddrIn[WAIT_LSB +: WAIT_W]);
  assign cas_d  = nz8(AddrIn[CAS_LSB  +: CAS_W]);
`else
  assign lat_d  = AddrIn[LAT_LSB  +: LAT_W];
  assign pre_d  = AddrIn[PRE_LSB  +: PRE_W];
  assign wait_d = AddrIn[WAIT_LSB +: WAIT_W];
  assign cas_d  = AddrIn[CAS_LSB  +: CAS_W];
`endif

  // Reset has priority over a coincident LMR; all fields load as one word
  always_ff @(posedge Clk) begin
    if (Rst) begin
      tburst    <= RST_TBURST;
      addr_mode <= 1'b0;
      tlat      <= RST_TLAT;
      tpre      <= RST_TPRE;
      twait     <= RST_TWAIT;
      tcas      <= RST_TCAS;
    end else if (lmr) begin
      tburst    <= beats;
      addr_mode <= AddrIn[AM_LSB];
      tlat      <= lat_d;
      tpre      <= pre_d;
      twait     <= wait_d;
      tcas      <= cas_d;
    end
  end

endmodule

// File: tb/tb_sdram_mode_regfile.sv
// Directed + random bench for sdram_mode_regfile using an expected-value queue.
module tb_sdram_mode_regfile;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        CS, RAS, CAS, WeIn;
  logic [31:0] AddrIn;
  logic [7:0]  tburst;
  logic        addr_mode;
  logic [3:0]  tlat;
  logic [7:0]  tpre;
  logic [7:0]  twait;
  logic [7:0]  tcas;

  // {tburst, addr_mode, tlat, tpre, twait, tcas}
  localparam int W = 37;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] model;
  logic [W-1:0] rst_word;

  int n_assert = 0;
  int n_fail   = 0;

  localparam logic [3:0] C_LMR = 4'b0000;
  localparam logic [3:0] C_NOP = 4'b1111;

  sdram_mode_regfile dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .CS        (CS),
    .RAS       (RAS),
    .CAS       (CAS),
    .WeIn      (WeIn),
    .AddrIn    (AddrIn),
    .tburst    (tburst),
    .addr_mode (addr_mode),
    .tlat      (tlat),
    .tpre      (tpre),
    .twait     (twait),
    .tcas      (tcas)
  );

  always #5 Clk = ~Clk;

  function automatic logic [W-1:0] pack(input logic [7:0] b, input logic am,
                                        input logic [3:0] l, input logic [7:0] p,
                                        input logic [7:0] w, input logic [7:0] c);
    return {b, am, l, p, w, c};
  endfunction

  // Reference decode of a mode word, written from the field map
  function automatic logic [W-1:0] decode(input logic [31:0] a);
    logic [7:0] b;
    logic [3:0] l;
    logic [7:0] p, w, c;
    b = 8'd0;
    case (a[2:0])
      3'd0: b = 8'd1;   3'd1: b = 8'd2;   3'd2: b = 8'd4;   3'd3: b = 8'd8;
      3'd4: b = 8'd16;  3'd5: b = 8'd32;  3'd6: b = 8'd64;  default: b = 8'd128;
    endcase
    l = a[7:4];
    p = a[15:8];
    w = a[23:16];
    c = a[31:24];
`ifdef SDRAM_REGFILE_CLAMP_EN
    if (l == 4'd0) l = 4'd1;
    if (p == 8'd0) p = 8'd1;
    if (w == 8'd0) w = 8'd1;
    if (c == 8'd0) c = 8'd1;
`endif
    return pack(b, a[3], l, p, w, c);
  endfunction

  task automatic cmp(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic check_out(input string step);
    logic [W-1:0] e;
    n_assert++;
    assert (exp_q.size() != 0) else begin
      n_fail++;
      $error("FAIL %s_queue observed=empty expected=entry", step);
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      cmp({step, ".tburst"},    tburst,            e[36:29]);
      cmp({step, ".addr_mode"}, {7'd0, addr_mode}, {7'd0, e[28]});
      cmp({step, ".tlat"},      {4'd0, tlat},      {4'd0, e[27:24]});
      cmp({step, ".tpre"},      tpre,              e[23:16]);
      cmp({step, ".twait"},     twait,             e[15:8]);
      cmp({step, ".tcas"},      tcas,              e[7:0]);
    end
  endtask

  // Drive one cycle of stimulus, queue its expectation, check after the edge
  task automatic step(input string name, input logic rst_v, input logic [3:0] cmd,
                      input logic [31:0] addr, input logic [W-1:0] exp);
    Rst = rst_v;
    {CS, RAS, CAS, WeIn} = cmd;
    AddrIn = addr;
    exp_q.push_back(exp);
    @(posedge Clk);
    #1;
    check_out(name);
  endtask

  initial begin
    logic [31:0] a;
    logic [W-1:0] zero_exp;
    rst_word = pack(8'd1, 1'b0, 4'd2, 8'd2, 8'd2, 8'd2);
    Rst = 1'b1;
    {CS, RAS, CAS, WeIn} = C_NOP;
    AddrIn = 32'd0;

    step("reset0", 1'b1, C_NOP, 32'd0, rst_word);
    step("reset1", 1'b1, C_NOP, 32'd0, rst_word);

    model = pack(8'd128, 1'b1, 4'd10, 8'd3, 8'd3, 8'd3);
    step("lmr_af", 1'b0, C_LMR, 32'h030303AF, model);
    step("nop_hold", 1'b0, C_NOP, 32'h050505C6, model);

    model = pack(8'd64, 1'b0, 4'd12, 8'd5, 8'd5, 8'd5);
    step("lmr_c6", 1'b0, C_LMR, 32'h050505C6, model);
    step("cs_high", 1'b0, 4'b1000, 32'h01020304, model);
    step("we_high", 1'b0, 4'b0001, 32'h01020304, model);
    step("ras_high", 1'b0, 4'b0100, 32'h01020304, model);
    step("cas_high", 1'b0, 4'b0010, 32'h01020304, model);

    // LMR held across cycles: each edge reloads, last word wins
    model = decode(32'h11223344);
    step("lmr_hold0", 1'b0, C_LMR, 32'h11223344, model);
    step("lmr_hold1", 1'b0, C_LMR, 32'h11223344, model);
    model = decode(32'h99887765);
    step("lmr_hold2", 1'b0, C_LMR, 32'h99887765, model);

    step("rst_lmr", 1'b1, C_LMR, 32'h030303AF, rst_word);
    model = rst_word;

`ifdef SDRAM_REGFILE_CLAMP_EN
    zero_exp = pack(8'd1, 1'b0, 4'd1, 8'd1, 8'd1, 8'd1);
`else
    zero_exp = pack(8'd1, 1'b0, 4'd0, 8'd0, 8'd0, 8'd0);
`endif
    step("lmr_zero", 1'b0, C_LMR, 32'h00000000, zero_exp);

    for (int i = 0; i < 12; i++) begin
      a = $urandom;
      if (i == 3) a[15:8] = 8'd0;
      model = decode(a);
      step("lmr_rand", 1'b0, C_LMR, a, model);
      step("nop_rand", 1'b0, 4'($urandom_range(1, 15)), $urandom, model);
    end

    step("rst_mid", 1'b1, C_NOP, 32'hFFFFFFFF, rst_word);
    step("after_rst", 1'b0, C_NOP, 32'hFFFFFFFF, rst_word);

    n_assert++;
    assert (exp_q.size() == 0) else begin
      n_fail++;
      $error("FAIL queue_drain observed=%0d expected=0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
